memory_tank_scheduler: RTL and testbench

Access sequencer for one mercury-delay-line store tank (16 long / 32 short words circulating). Tracks which short-word slot is currently emerging from the tank using free-running digit and word counters on `f2_clk`. Accepts one read or write request at a time, waits for the addressed slot to come round, then drives the tank's clear, input and output gates for exactly that word's digit window. Sits between the store-address decode and a single tank instance such as the F2 down tanks.

---
 rtl/memory_pkg.sv | 24 ++
 rtl/memory_tank_timer.sv | 51 +++++
 rtl/memory_tank_scheduler.sv | 149 ++++++++++++++
 tb/tb_memory_tank_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
`default_nettype none
// =====================================================================
// memory_pkg : shared types and default geometry for delay-line tank controllers
// Revision   : 1.0
// =====================================================================
package memory_pkg;

   localparam int C_DEFAULT_DIGITS = 18;
   localparam int C_DEFAULT_SLOTS  = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_GATE = 2'd2,
      ST_DONE = 2'd3
   } tank_state_e;

   typedef enum logic {
      GATE_READ  = 1'b0,
      GATE_WRITE = 1'b1
   } gate_sel_e;

endpackage
`default_nettype wire

// File: rtl/memory_tank_timer.sv
`default_nettype none
// =====================================================================
// memory_tank_timer : free-running digit/slot counters shared by all tanks
// Revision          : 1.0
// =====================================================================
module memory_tank_timer
   import memory_pkg::*;
#(
   parameter int DIGITS = C_DEFAULT_DIGITS,
   parameter int SLOTS  = C_DEFAULT_SLOTS
) (
   input  logic                      f2_clk,
   input  logic                      f2_rst,
   output logic [$clog2(DIGITS)-1:0] digit_pos,
   output logic [$clog2(SLOTS)-1:0]  slot_pos,
   output logic                      slot_start_next
);

   localparam int DW = $clog2(DIGITS);
   localparam int SW = $clog2(SLOTS);
   localparam logic [DW-1:0] C_DIGIT_LAST = DW'(DIGITS - 1);

   logic [DW-1:0] digit_q, digit_d;
   logic [SW-1:0] slot_q, slot_d;

   // SLOTS is a power of two, so the slot counter wraps on its own.
   always_comb begin
      digit_d = digit_q + 1'b1;
      slot_d  = slot_q;
      if (digit_q == C_DIGIT_LAST) begin
         digit_d = '0;
         slot_d  = slot_q + 1'b1;
      end
   end

   always_ff @(posedge f2_clk) begin
      if (f2_rst) begin
         digit_q <= '0;
         slot_q  <= '0;
      end else begin
         digit_q <= digit_d;
         slot_q  <= slot_d;
      end
   end

   assign digit_pos       = digit_q;
   assign slot_pos        = slot_q;
   assign slot_start_next = (digit_q == C_DIGIT_LAST);

endmodule
`default_nettype wire

// File: rtl/memory_tank_scheduler.sv
`default_nettype none
// =====================================================================
// memory_tank_scheduler : slot-timed read/write gate sequencer for one tank (MEMORY_TANK_LONG_EN: long words)
// Revision              : 1.0
// =====================================================================
module memory_tank_scheduler
   import memory_pkg::*;
#(
   parameter int DIGITS = C_DEFAULT_DIGITS,
   parameter int SLOTS  = C_DEFAULT_SLOTS
) (
   input  logic                      f2_clk,
   input  logic                      f2_rst,
   input  logic                      req,
   input  logic                      req_we,
   input  logic                      req_long,
   input  logic [$clog2(SLOTS)-1:0]  req_addr,
   output logic                      req_ack,
   output logic                      busy,
   output logic                      done,
   output logic                      tank_clr,
   output logic                      tank_in,
   output logic                      tank_out,
   output logic [$clog2(DIGITS)-1:0] digit_pos,
   output logic [$clog2(SLOTS)-1:0]  slot_pos
);

   localparam int SW = $clog2(SLOTS);
`ifdef MEMORY_TANK_LONG_EN
   localparam int WW = $clog2(2 * DIGITS);
`else
   localparam int WW = $clog2(DIGITS);
`endif
   localparam logic [WW-1:0] C_SHORT_LAST = WW'(DIGITS - 1);

   tank_state_e   state_q, state_d;
   gate_sel_e     op_q, op_d;
   logic [SW-1:0] addr_q, addr_d;
   logic [WW-1:0] win_q, win_d;
   logic          ack_q, ack_d;

   logic          w_slot_start_next;
   logic          w_req_long;
   logic [SW-1:0] w_req_addr;
   logic [WW-1:0] w_win_last;
   logic          w_hit_req;
   logic          w_hit_wait;
   logic          w_gate;

   memory_tank_timer #(
      .DIGITS (DIGITS),
      .SLOTS  (SLOTS)
   ) u_timer (
      .f2_clk          (f2_clk),
      .f2_rst          (f2_rst),
      .digit_pos       (digit_pos),
      .slot_pos        (slot_pos),
      .slot_start_next (w_slot_start_next)
   );

`ifdef MEMORY_TANK_LONG_EN
   localparam logic [WW-1:0] C_LONG_LAST = WW'(2 * DIGITS - 1);

   logic long_q, long_d;

   assign w_req_long = req_long;
   assign w_win_last = long_q ? C_LONG_LAST : C_SHORT_LAST;

   always_comb begin
      long_d = long_q;
      if ((state_q == ST_IDLE) && req) long_d = w_req_long;
   end

   always_ff @(posedge f2_clk) begin
      if (f2_rst) long_q <= 1'b0;
      else        long_q <= long_d;
   end
`else
   logic unused_req_long;

   assign unused_req_long = req_long;
   assign w_req_long      = 1'b0;
   assign w_win_last      = C_SHORT_LAST;
`endif

   assign w_req_addr = w_req_long ? {req_addr[SW-1:1], 1'b0} : req_addr;

   // Decide one digit early so GATE is entered exactly on digit 0 of the slot
   // and the gates stay pure functions of registered state.
   assign w_hit_req  = w_slot_start_next && (slot_pos == (w_req_addr - SW'(1)));
   assign w_hit_wait = w_slot_start_next && (slot_pos == (addr_q - SW'(1)));

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      win_d   = win_q;
      ack_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               op_d    = req_we ? GATE_WRITE : GATE_READ;
               addr_d  = w_req_addr;
               ack_d   = 1'b1;
               win_d   = '0;
               state_d = w_hit_req ? ST_GATE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (w_hit_wait) begin
               win_d   = '0;
               state_d = ST_GATE;
            end
         end
         ST_GATE: begin
            if (win_q == w_win_last) state_d = ST_DONE;
            else                     win_d   = win_q + 1'b1;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge f2_clk) begin
      if (f2_rst) begin
         state_q <= ST_IDLE;
         op_q    <= GATE_READ;
         addr_q  <= '0;
         win_q   <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         win_q   <= win_d;
         ack_q   <= ack_d;
      end
   end

   assign w_gate   = (state_q == ST_GATE);
   assign req_ack  = ack_q;
   assign busy     = (state_q == ST_WAIT) || (state_q == ST_GATE);
   assign done     = (state_q == ST_DONE);
   assign tank_clr = w_gate && (op_q == GATE_WRITE);
   assign tank_in  = w_gate && (op_q == GATE_WRITE);
   assign tank_out = w_gate && (op_q == GATE_READ);

endmodule
`default_nettype wire

// File: tb/tb_memory_tank_scheduler.sv
`default_nettype none
// =====================================================================
// tb_memory_tank_scheduler : directed scoreboard bench for memory_tank_scheduler
// Revision                 : 1.0
// =====================================================================
module tb_memory_tank_scheduler;

`ifdef MEMORY_TANK_LONG_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic       f2_clk = 1'b0;
   logic       f2_rst = 1'b1;
   logic       req = 1'b0;
   logic       req_we = 1'b0;
   logic       req_long = 1'b0;
   logic [4:0] req_addr = '0;
   logic       req_ack, busy, done, tank_clr, tank_in, tank_out;
   logic [4:0] digit_pos, slot_pos;

   typedef struct {
      string       tag;
      logic [2:0]  gates;
      int          slot;
      int          len;
      int          lat;
      int unsigned t_acc;
      int          done_slot;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned tcount = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   int          n_fail = 0;

   memory_tank_scheduler dut (
      .f2_clk    (f2_clk),
      .f2_rst    (f2_rst),
      .req       (req),
      .req_we    (req_we),
      .req_long  (req_long),
      .req_addr  (req_addr),
      .req_ack   (req_ack),
      .busy      (busy),
      .done      (done),
      .tank_clr  (tank_clr),
      .tank_in   (tank_in),
      .tank_out  (tank_out),
      .digit_pos (digit_pos),
      .slot_pos  (slot_pos)
   );

   always #5 f2_clk = ~f2_clk;

   // Reference time base: digit and slot follow from cycles since reset.
   always @(posedge f2_clk) begin
      if (f2_rst) tcount <= 0;
      else        tcount <= tcount + 1;
   end

   function automatic logic [4:0] ref_digit();
      return 5'(tcount % 18);
   endfunction

   function automatic logic [4:0] ref_slot();
      return 5'((tcount / 18) % 32);
   endfunction

   function automatic logic [2:0] gates();
      return {tank_clr, tank_in, tank_out};
   endfunction

   task automatic tick();
      @(posedge f2_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
      end
   endtask

   task automatic wait_pos(input int s, input int d);
      int n = 0;
      while (!(ref_slot() == 5'(s) && ref_digit() == 5'(d)) && n < 600) begin
         tick();
         n++;
      end
      chk($sformatf("reach_pos_%0d_%0d", s, d), 32'(n < 600), 1);
   endtask

   // Drive one request in the current cycle and queue what the tank should do.
   task automatic issue(input logic we, input logic lng, input int addr, input string tag);
      exp_t e;
      int   eff, len, cur, lat;
      eff = (LONG_EN && lng) ? (addr & ~1) : addr;
      len = (LONG_EN && lng) ? 36 : 18;
      cur = int'(tcount % 576);
      lat = (eff * 18 - cur + 576) % 576;
      if (lat == 0) lat = 576;
      e.tag       = tag;
      e.gates     = we ? 3'b110 : 3'b001;
      e.slot      = eff;
      e.len       = len;
      e.lat       = lat;
      e.t_acc     = tcount;
      e.done_slot = (eff + len / 18) % 32;
      exp_q.push_back(e);
      req      = 1'b1;
      req_we   = we;
      req_long = lng;
      req_addr = 5'(addr);
      tick();
      chk({tag, "_ack"}, 32'(req_ack), 1);
      chk({tag, "_busy"}, 32'(busy), 1);
      req = 1'b0;
   endtask

   task automatic run_access();
      exp_t e;
      int   waited, len;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      waited = 0;
      while (gates() == 3'b000 && waited < 700) begin
         tick();
         waited++;
      end
      chk({e.tag, "_gate_seen"}, 32'(gates() != 3'b000), 1);
      if (gates() == 3'b000) return;
      chk({e.tag, "_start_slot"}, 32'(slot_pos), 32'(e.slot));
      chk({e.tag, "_start_digit"}, 32'(digit_pos), 0);
      chk({e.tag, "_latency"}, tcount - e.t_acc, 32'(e.lat));
      len = 0;
      while (gates() != 3'b000 && len < 80) begin
         chk({e.tag, "_gates"}, 32'(gates()), 32'(e.gates));
         len++;
         tick();
      end
      chk({e.tag, "_window"}, 32'(len), 32'(e.len));
      chk({e.tag, "_done"}, 32'(done), 1);
      chk({e.tag, "_done_slot"}, 32'(slot_pos), 32'(e.done_slot));
      chk({e.tag, "_done_digit"}, 32'(digit_pos), 0);
      tick();
      chk({e.tag, "_after_done"}, 32'({done, busy, req_ack, gates()}), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      int   w;

      repeat (5) tick();
      chk("reset_outputs", 32'({req_ack, busy, done, tank_clr, tank_in, tank_out}), 0);
      chk("reset_digit", 32'(digit_pos), 0);
      chk("reset_slot", 32'(slot_pos), 0);
      f2_rst = 1'b0;

      // Free-running counters across a full circulation and its wrap.
      for (int i = 0; i < 600; i++) begin
         chk("counters", 32'({slot_pos, digit_pos}), 32'({ref_slot(), ref_digit()}));
         chk("idle_outputs", 32'({req_ack, busy, done, gates()}), 0);
         tick();
      end

      wait_pos(3, 4);
      issue(1'b0, 1'b0, 5, "rd5");
      run_access();

      issue(1'b1, 1'b1, 7, "wrl7");
      run_access();

      issue(1'b0, 1'b1, 7, "rdl7");
      run_access();

      issue(1'b1, 1'b1, 30, "wrl30");
      run_access();

      // Accept on the target slot's digit 0: full circulation; extra req ignored.
      wait_pos(10, 0);
      issue(1'b0, 1'b0, 10, "rd10");
      for (int i = 0; i < 5; i++) begin
         req = 1'b1;
         tick();
         chk("wait_req_no_ack", 32'(req_ack), 0);
         chk("wait_busy", 32'(busy), 1);
      end
      req = 1'b0;
      run_access();

      wait_pos(31, 17);
      issue(1'b1, 1'b0, 0, "wr0");
      run_access();

      // Reset on the 10th gate cycle of a write.
      wait_pos(11, 3);
      issue(1'b1, 1'b0, 12, "wr12");
      e = exp_q.pop_back();
      w = 0;
      while (gates() == 3'b000 && w < 700) begin
         tick();
         w++;
      end
      chk("rst_gate_seen", 32'(gates() != 3'b000), 1);
      chk("rst_gate_slot", 32'(slot_pos), 32'(e.slot));
      repeat (9) tick();
      chk("rst_gate10", 32'(gates()), 32'(e.gates));
      f2_rst = 1'b1;
      tick();
      chk("rst_gates_drop", 32'({done, gates()}), 0);
      chk("rst_counters", 32'({slot_pos, digit_pos}), 0);
      f2_rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         chk("post_rst_quiet", 32'({req_ack, busy, done, gates()}), 0);
         chk("post_rst_counters", 32'({slot_pos, digit_pos}), 32'({ref_slot(), ref_digit()}));
      end

      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
